// File: rtl/nios_project_mem_check_master.sv
// nios_project_mem_check_master
// Memory check master. It writes an incrementing pattern (seed + i) over a
// word region, reads the region back and compares the read data against
// the same pattern after the slave's read latency.
//
// Build option: NIOS_PROJECT_MEM_CHECK_VERIFY_EN
//   defined   : FILL, then READ, then DRAIN with read-back comparison
//   undefined : fill only; FILL goes straight to DONE with pass=1
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   start                     run request, honoured only in IDLE/DONE
//   base_addr[12:0]           first word address (addresses wrap at 8192)
//   length[13:0]              word count, 0..8192
//   seed_sel, seed[31:0]      pattern seed select (0 -> SEED_DEFAULT)
//   avm_*                     memory-mapped master toward the slave
//   busy, done, pass          run status
//   err_count[13:0]           mismatch count, saturating at 8192
//   first_err_addr[12:0]      address of the first mismatch
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | out of reset, waiting for start
// S_FILL  | one pattern write per cycle
// S_READ  | one read per cycle over the same addresses
// S_DRAIN | READ_LATENCY cycles waiting for the last read data
// S_DONE  | status valid, waiting for the next start
module nios_project_mem_check_master #(
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [31:0] SEED_DEFAULT = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [12:0] base_addr,
   input  logic [13:0] length,
   input  logic        seed_sel,
   input  logic [31:0] seed,
   output logic [12:0] avm_address,
   output logic [3:0]  avm_byteenable,
   output logic        avm_chipselect,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic        avm_clken,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [13:0] err_count,
   output logic [12:0] first_err_addr
);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_READ, S_DRAIN, S_DONE} state_t;

   state_t      state_q;
   logic [12:0] addr_q;
   logic [31:0] wdata_q;
   logic [13:0] rem_q;
   logic        cs_q, wr_q, busy_q, done_q, pass_q;
   logic [13:0] err_q;
   logic [12:0] ferr_q;
   logic        mismatch;
   logic [12:0] cmp_addr;
   logic [31:0] seed_pick;

   assign seed_pick = seed_sel ? seed : SEED_DEFAULT;

`ifdef NIOS_PROJECT_MEM_CHECK_VERIFY_EN
   logic [12:0] base_q;
   logic [31:0] seed_q, exp_q;
   logic [13:0] len_q;
   logic [1:0]  drain_q;

   // Expected data/address ride along with each read until its data returns.
   logic [READ_LATENCY-1:0] pv_q;
   logic [12:0]             pa_q [READ_LATENCY];
   logic [31:0]             pd_q [READ_LATENCY];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pv_q <= '0;
         for (int k = 0; k < READ_LATENCY; k++) begin
            pa_q[k] <= '0;
            pd_q[k] <= '0;
         end
      end else begin
         pv_q[0] <= cs_q & ~wr_q;
         pa_q[0] <= addr_q;
         pd_q[0] <= exp_q;
         for (int k = 1; k < READ_LATENCY; k++) begin
            pv_q[k] <= pv_q[k-1];
            pa_q[k] <= pa_q[k-1];
            pd_q[k] <= pd_q[k-1];
         end
      end
   end

   assign mismatch = pv_q[READ_LATENCY-1] && (avm_readdata != pd_q[READ_LATENCY-1]);
   assign cmp_addr = pa_q[READ_LATENCY-1];
`else
   logic unused_ok;
   assign unused_ok = ^avm_readdata;
   assign mismatch  = 1'b0;
   assign cmp_addr  = '0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rem_q   <= '0;
         cs_q    <= 1'b0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         ferr_q  <= '0;
`ifdef NIOS_PROJECT_MEM_CHECK_VERIFY_EN
         base_q  <= '0;
         seed_q  <= '0;
         exp_q   <= '0;
         len_q   <= '0;
         drain_q <= '0;
`endif
      end else begin
         if (mismatch) begin
            if (err_q != 14'd8192) err_q <= err_q + 14'd1;
            if (err_q == 14'd0)    ferr_q <= cmp_addr;
         end
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  err_q  <= '0;
                  ferr_q <= '0;
`ifdef NIOS_PROJECT_MEM_CHECK_VERIFY_EN
                  base_q <= base_addr;
                  seed_q <= seed_pick;
                  len_q  <= length;
`endif
                  if (length == 14'd0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     pass_q  <= 1'b1;
                  end else begin
                     state_q <= S_FILL;
                     done_q  <= 1'b0;
                     pass_q  <= 1'b0;
                     busy_q  <= 1'b1;
                     cs_q    <= 1'b1;
                     wr_q    <= 1'b1;
                     addr_q  <= base_addr;
                     wdata_q <= seed_pick;
                     rem_q   <= length - 14'd1;
                  end
               end
            end
            S_FILL: begin
               if (rem_q != 14'd0) begin
                  addr_q  <= addr_q + 13'd1;
                  wdata_q <= wdata_q + 32'd1;
                  rem_q   <= rem_q - 14'd1;
               end else begin
                  wr_q    <= 1'b0;
                  wdata_q <= '0;
`ifdef NIOS_PROJECT_MEM_CHECK_VERIFY_EN
                  state_q <= S_READ;
                  addr_q  <= base_q;
                  exp_q   <= seed_q;
                  rem_q   <= len_q - 14'd1;
`else
                  state_q <= S_DONE;
                  cs_q    <= 1'b0;
                  addr_q  <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= 1'b1;
`endif
               end
            end
`ifdef NIOS_PROJECT_MEM_CHECK_VERIFY_EN
            S_READ: begin
               if (rem_q != 14'd0) begin
                  addr_q <= addr_q + 13'd1;
                  exp_q  <= exp_q + 32'd1;
                  rem_q  <= rem_q - 14'd1;
               end else begin
                  state_q <= S_DRAIN;
                  cs_q    <= 1'b0;
                  addr_q  <= '0;
                  drain_q <= 2'(READ_LATENCY - 1);
               end
            end
            S_DRAIN: begin
               if (drain_q != 2'd0) begin
                  drain_q <= drain_q - 2'd1;
               end else begin
                  // The last compare lands on this edge, so fold it into pass.
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_q == 14'd0) && !mismatch;
               end
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign avm_address    = addr_q;
   assign avm_chipselect = cs_q;
   assign avm_byteenable = {4{cs_q}};
   assign avm_write      = wr_q;
   assign avm_writedata  = wdata_q;
   assign avm_clken      = 1'b1;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_err_addr = ferr_q;

endmodule
